mdio_phy_monitor: RTL and testbench

- Command-side master for `mdio_master`: drives its cmd interface and consumes its `data_out` stream.
- After reset it performs PHY bring-up:
  - optional disable of 1000BASE-T advertisement;
  - auto-negotiation restart.
- It then polls BMSR/ANAR/ANLPAR periodically and publishes link, speed and duplex to the Ethernet core and debug logic.
- Sits between the top-level reset/trigger logic and `mdio_master`, in the 125 MHz domain.

---
 rtl/mdio_pkg.sv | 41 ++++
 rtl/mdio_phy_monitor.sv | 186 ++++++++++++++++++
 tb/tb_mdio_phy_monitor.sv | 336 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mdio_pkg.sv
// Shared MDIO register map, opcodes, status bit positions and the monitor state encoding.
package mdio_pkg;

  localparam logic [4:0] REG_BMCR   = 5'h00;
  localparam logic [4:0] REG_BMSR   = 5'h01;
  localparam logic [4:0] REG_ANAR   = 5'h04;
  localparam logic [4:0] REG_ANLPAR = 5'h05;
  localparam logic [4:0] REG_GBCR   = 5'h09;

  localparam logic [1:0] MDIO_OP_WRITE = 2'b01;
  localparam logic [1:0] MDIO_OP_READ  = 2'b10;

  localparam int BMSR_LINK  = 2;
  localparam int BMSR_ANC   = 5;
  localparam int ABIL_100FD = 8;

  // AN enable + AN restart + full duplex + 1000M speed-select bits
  localparam logic [15:0] BMCR_AN_RESTART = 16'h1340;

  typedef enum logic [3:0] {
    S_DELAY,
    S_WR_GB,
    S_WR_BMCR,
    S_WAIT,
    S_RD_BMSR,
    S_RSP_BMSR,
    S_RD_ANAR,
    S_RSP_ANAR,
    S_RD_ANLPAR,
    S_RSP_ANLPAR,
    S_UPDATE,
    S_FAIL
  } state_t;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/mdio_phy_monitor.sv
// PHY bring-up and periodic BMSR/ANAR/ANLPAR poller driving mdio_master's command port.
// Publishes link, speed and duplex; a restart edge re-runs bring-up once any presented command is accepted.
module mdio_phy_monitor
  import mdio_pkg::*;
#(
  parameter logic [4:0] PHY_ADDR      = 5'h00,
  parameter int         INIT_DELAY    = 65535,
  parameter int         POLL_INTERVAL = 1250000,
  parameter int         RESP_TIMEOUT  = 4096,
  parameter bit         DISABLE_1G    = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        restart,
  output logic [4:0]  cmd_phy_addr,
  output logic [4:0]  cmd_reg_addr,
  output logic [15:0] cmd_data,
  output logic [1:0]  cmd_opcode,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  input  logic [15:0] data_out,
  input  logic        data_out_valid,
  output logic        data_out_ready,
  output logic        link_up,
  output logic        an_complete,
  output logic        speed_100,
  output logic        full_duplex,
  output logic        status_valid,
  output logic        link_change,
  output logic        timeout_err,
  output logic        init_done
);

  localparam int CW = $clog2(max3(INIT_DELAY, POLL_INTERVAL, RESP_TIMEOUT)) + 1;
  localparam logic [CW-1:0] INIT_LD = CW'(INIT_DELAY);
  localparam logic [CW-1:0] POLL_LD = CW'(POLL_INTERVAL);
  localparam logic [CW-1:0] RESP_LD = CW'(RESP_TIMEOUT);

  state_t        state;
  state_t        after;
  logic [CW-1:0] cnt;
  logic          restart_q;
  logic          abort_pend;
  logic          bmsr_link;
  logic          bmsr_anc;
  logic [3:0]    anar_abil;
  logic [3:0]    anlpar_abil;
  logic [3:0]    common;
  logic          is_cmd;
  logic          is_rsp;
  logic [4:0]    tgt_reg;
  logic [15:0]   tgt_data;
  logic [1:0]    tgt_op;
  logic          abort_req;
  logic          cmd_busy;

  assign cmd_phy_addr   = PHY_ADDR;
  assign data_out_ready = 1'b1;
  assign abort_req      = (restart & ~restart_q) | abort_pend;
  assign cmd_busy       = cmd_valid & ~cmd_ready;
  assign common         = anar_abil & anlpar_abil;

  // Command target and successor for every state that issues or awaits a transfer.
  always_comb begin
    is_cmd   = 1'b0;
    is_rsp   = 1'b0;
    tgt_reg  = REG_BMCR;
    tgt_data = 16'h0000;
    tgt_op   = MDIO_OP_READ;
    after    = state;
    case (state)
      S_WR_GB:      begin is_cmd = 1'b1; tgt_reg = REG_GBCR; tgt_op = MDIO_OP_WRITE; after = S_WR_BMCR; end
      S_WR_BMCR:    begin is_cmd = 1'b1; tgt_data = BMCR_AN_RESTART; tgt_op = MDIO_OP_WRITE; after = S_WAIT; end
      S_RD_BMSR:    begin is_cmd = 1'b1; tgt_reg = REG_BMSR; after = S_RSP_BMSR; end
      S_RD_ANAR:    begin is_cmd = 1'b1; tgt_reg = REG_ANAR; after = S_RSP_ANAR; end
      S_RD_ANLPAR:  begin is_cmd = 1'b1; tgt_reg = REG_ANLPAR; after = S_RSP_ANLPAR; end
      S_RSP_BMSR:   begin is_rsp = 1'b1; after = S_RD_ANAR; end
      S_RSP_ANAR:   begin is_rsp = 1'b1; after = S_RD_ANLPAR; end
      S_RSP_ANLPAR: begin is_rsp = 1'b1; after = S_UPDATE; end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_DELAY;
      cnt          <= INIT_LD;
      restart_q    <= 1'b0;
      abort_pend   <= 1'b0;
      cmd_valid    <= 1'b0;
      cmd_opcode   <= MDIO_OP_WRITE;
      cmd_reg_addr <= REG_BMCR;
      cmd_data     <= 16'h0000;
      bmsr_link    <= 1'b0;
      bmsr_anc     <= 1'b0;
      anar_abil    <= 4'h0;
      anlpar_abil  <= 4'h0;
      link_up      <= 1'b0;
      an_complete  <= 1'b0;
      speed_100    <= 1'b0;
      full_duplex  <= 1'b0;
      status_valid <= 1'b0;
      link_change  <= 1'b0;
      timeout_err  <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      restart_q   <= restart;
      link_change <= 1'b0;
      if (abort_req && !cmd_busy) begin
        abort_pend   <= 1'b0;
        cmd_valid    <= 1'b0;
        init_done    <= 1'b0;
        status_valid <= 1'b0;
        cnt          <= INIT_LD;
        state        <= S_DELAY;
      end else if (abort_req) begin
        // A presented command must complete its handshake before we can abandon it.
        abort_pend <= 1'b1;
      end else if (is_cmd) begin
        if (cmd_valid) begin
          if (cmd_ready) begin
            cmd_valid <= 1'b0;
            state     <= after;
            cnt       <= (state == S_WR_BMCR) ? POLL_LD : RESP_LD;
            if (state == S_WR_BMCR) init_done <= 1'b1;
          end
        end else if (cmd_ready) begin
          cmd_valid    <= 1'b1;
          cmd_reg_addr <= tgt_reg;
          cmd_data     <= tgt_data;
          cmd_opcode   <= tgt_op;
        end
      end else if (is_rsp) begin
        if (data_out_valid) begin
          case (state)
            S_RSP_BMSR: begin
              bmsr_link <= data_out[BMSR_LINK];
              bmsr_anc  <= data_out[BMSR_ANC];
            end
            S_RSP_ANAR: anar_abil   <= data_out[ABIL_100FD -: 4];
            default:    anlpar_abil <= data_out[ABIL_100FD -: 4];
          endcase
          state <= after;
        end else if (cnt == '0) begin
          state <= S_FAIL;
        end else begin
          cnt <= cnt - CW'(1);
        end
      end else begin
        case (state)
          S_DELAY: begin
            if (cnt == '0) state <= DISABLE_1G ? S_WR_GB : S_WR_BMCR;
            else cnt <= cnt - CW'(1);
          end
          S_WAIT: begin
            if (cnt == '0) state <= S_RD_BMSR;
            else cnt <= cnt - CW'(1);
          end
          S_UPDATE: begin
            link_up      <= bmsr_link;
            an_complete  <= bmsr_anc;
            link_change  <= bmsr_link ^ link_up;
            speed_100    <= common[3] | common[2];
            full_duplex  <= common[3] | (~common[2] & common[1]);
            status_valid <= 1'b1;
            timeout_err  <= 1'b0;
            cnt          <= POLL_LD;
            state        <= S_WAIT;
          end
          S_FAIL: begin
            timeout_err <= 1'b1;
            link_up     <= 1'b0;
            link_change <= link_up;
            cnt         <= POLL_LD;
            state       <= S_WAIT;
          end
          default: begin
            cnt   <= INIT_LD;
            state <= S_DELAY;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mdio_phy_monitor.sv
// Directed bench for mdio_phy_monitor with a behavioural mdio_master model (20-cycle ready holdoff).
module tb_mdio_phy_monitor;

  logic        clk = 1'b0;
  logic        rst;
  logic        restart;
  logic [4:0]  cmd_phy_addr, cmd_reg_addr;
  logic [15:0] cmd_data;
  logic [1:0]  cmd_opcode;
  logic        cmd_valid, cmd_ready;
  logic [15:0] data_out;
  logic        data_out_valid, data_out_ready;
  logic        link_up, an_complete, speed_100, full_duplex;
  logic        status_valid, link_change, timeout_err, init_done;

  logic        restart_b;
  logic [4:0]  cmd_phy_addr_b, cmd_reg_addr_b;
  logic [15:0] cmd_data_b;
  logic [1:0]  cmd_opcode_b;
  logic        cmd_valid_b, cmd_ready_b;
  logic [15:0] data_out_b;
  logic        data_out_valid_b, data_out_ready_b;
  logic        link_up_b, an_complete_b, speed_100_b, full_duplex_b;
  logic        status_valid_b, link_change_b, timeout_err_b, init_done_b;

  int checks = 0;
  int failures = 0;

  int          cyc = 0;
  int          busy = 0;
  int          resp_wait = 0;
  int          lc_cnt = 0;
  int          anlpar_served = 0;
  int          anar_acc_cyc = 0;
  bit          drop_next = 0;
  bit          stall_req = 0;
  bit          stalled = 0;
  bit          withhold_anar = 0;
  logic [4:0]  resp_reg = 5'h0;
  logic [15:0] bmsr_val, anar_val, anlpar_val;
  logic [27:0] log_q[$];
  int          log_cyc[$];
  logic [27:0] log0_q[$];

  always #4 clk = ~clk;

  mdio_phy_monitor #(
    .PHY_ADDR(5'h00), .INIT_DELAY(10), .POLL_INTERVAL(100), .RESP_TIMEOUT(50), .DISABLE_1G(1'b1)
  ) dut (
    .clk(clk), .rst(rst), .restart(restart),
    .cmd_phy_addr(cmd_phy_addr), .cmd_reg_addr(cmd_reg_addr), .cmd_data(cmd_data),
    .cmd_opcode(cmd_opcode), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .data_out(data_out), .data_out_valid(data_out_valid), .data_out_ready(data_out_ready),
    .link_up(link_up), .an_complete(an_complete), .speed_100(speed_100), .full_duplex(full_duplex),
    .status_valid(status_valid), .link_change(link_change), .timeout_err(timeout_err),
    .init_done(init_done)
  );

  mdio_phy_monitor #(
    .PHY_ADDR(5'h07), .INIT_DELAY(10), .POLL_INTERVAL(100), .RESP_TIMEOUT(50), .DISABLE_1G(1'b0)
  ) dut_b (
    .clk(clk), .rst(rst), .restart(restart_b),
    .cmd_phy_addr(cmd_phy_addr_b), .cmd_reg_addr(cmd_reg_addr_b), .cmd_data(cmd_data_b),
    .cmd_opcode(cmd_opcode_b), .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b),
    .data_out(data_out_b), .data_out_valid(data_out_valid_b), .data_out_ready(data_out_ready_b),
    .link_up(link_up_b), .an_complete(an_complete_b), .speed_100(speed_100_b),
    .full_duplex(full_duplex_b), .status_valid(status_valid_b), .link_change(link_change_b),
    .timeout_err(timeout_err_b), .init_done(init_done_b)
  );

  assign cmd_ready_b      = 1'b1;
  assign data_out_b       = 16'h0000;
  assign data_out_valid_b = 1'b0;
  assign restart_b        = 1'b0;

  // mdio_master model: at each negedge the values seen are those the next posedge will use.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (link_change) lc_cnt = lc_cnt + 1;
    data_out_valid = 1'b0;
    if (cmd_valid_b && cmd_ready_b)
      log0_q.push_back({cmd_phy_addr_b, cmd_reg_addr_b, cmd_opcode_b, cmd_data_b});
    if (rst) begin
      cmd_ready = 1'b1; busy = 0; drop_next = 0; resp_wait = 0; stalled = 0;
    end else begin
      if (resp_wait > 0) begin
        resp_wait = resp_wait - 1;
        if (resp_wait == 0) begin
          case (resp_reg)
            5'h01: begin data_out = bmsr_val; data_out_valid = 1'b1; end
            5'h04: if (!withhold_anar) begin data_out = anar_val; data_out_valid = 1'b1; end
            5'h05: begin data_out = anlpar_val; data_out_valid = 1'b1; anlpar_served = anlpar_served + 1; end
            default: ;
          endcase
        end
      end
      if (drop_next) begin
        drop_next = 0; cmd_ready = 1'b0; busy = 20;
      end else if (busy > 0) begin
        busy = busy - 1;
        if (busy == 0) cmd_ready = 1'b1;
      end else if (stalled && !stall_req) begin
        stalled = 0; cmd_ready = 1'b1;
      end else if (!stalled && stall_req && cmd_valid && cmd_ready) begin
        stalled = 1; cmd_ready = 1'b0;
      end
      if (cmd_valid && cmd_ready) begin
        log_q.push_back({cmd_phy_addr, cmd_reg_addr, cmd_opcode, cmd_data});
        log_cyc.push_back(cyc);
        drop_next = 1;
        if (cmd_opcode == 2'b10) begin
          resp_wait = 6; resp_reg = cmd_reg_addr;
          if (cmd_reg_addr == 5'h04) anar_acc_cyc = cyc;
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_round(output bit ok);
    int n0 = anlpar_served;
    int k = 0;
    while (anlpar_served == n0 && k < 800) begin step(); k++; end
    ok = (anlpar_served != n0);
    repeat (3) step();
  endtask

  task automatic test_reset();
    step();
    checks++;
    if (cmd_valid !== 1'b0) begin failures++; $display("FAIL reset_cmd_valid got=%b exp=0", cmd_valid); end
    checks++;
    if (cmd_opcode !== 2'b01) begin failures++; $display("FAIL reset_cmd_opcode got=%b exp=01", cmd_opcode); end
    checks++;
    if ({link_up, an_complete, speed_100, full_duplex, status_valid, link_change, timeout_err, init_done} !== 8'h00) begin
      failures++; $display("FAIL reset_status got=%b exp=00000000",
        {link_up, an_complete, speed_100, full_duplex, status_valid, link_change, timeout_err, init_done});
    end
    checks++;
    if (data_out_ready !== 1'b1) begin failures++; $display("FAIL data_out_ready got=%b exp=1", data_out_ready); end
  endtask

  task automatic test_bringup();
    int k = 0;
    int rel;
    logic [27:0] e;
    log_q.delete(); log_cyc.delete();
    rel = cyc;
    rst = 1'b0;
    while (init_done !== 1'b1 && k < 200) begin step(); k++; end
    checks++;
    if (init_done !== 1'b1) begin failures++; $display("FAIL bringup_init_done got=%b exp=1", init_done); end
    checks++;
    if (log_q.size() != 2) begin failures++; $display("FAIL bringup_cmd_count got=%0d exp=2", log_q.size()); end
    e = (log_q.size() > 0) ? log_q[0] : 28'hxxxxxxx;
    checks++;
    if (e !== {5'h00, 5'h09, 2'b01, 16'h0000}) begin failures++; $display("FAIL bringup_gb_write got=%h exp=%h", e, {5'h00, 5'h09, 2'b01, 16'h0000}); end
    e = (log_q.size() > 1) ? log_q[1] : 28'hxxxxxxx;
    checks++;
    if (e !== {5'h00, 5'h00, 2'b01, 16'h1340}) begin failures++; $display("FAIL bringup_bmcr_write got=%h exp=%h", e, {5'h00, 5'h00, 2'b01, 16'h1340}); end
    k = (log_cyc.size() > 0) ? log_cyc[0] - rel : -1;
    checks++;
    if (k < 11 || k > 13) begin failures++; $display("FAIL bringup_first_cmd_delay got=%0d exp=11..13", k); end
    checks++;
    if ({link_up, an_complete, speed_100, full_duplex, status_valid, timeout_err} !== 6'h00) begin
      failures++; $display("FAIL bringup_status_idle got=%b exp=000000",
        {link_up, an_complete, speed_100, full_duplex, status_valid, timeout_err});
    end
  endtask

  task automatic test_good_round();
    int k = 0;
    logic [27:0] e;
    lc_cnt = 0;
    while (status_valid !== 1'b1 && k < 800) begin step(); k++; end
    step(); step();
    checks++;
    if ({link_up, an_complete, speed_100, full_duplex, status_valid, timeout_err} !== 6'b111110) begin
      failures++; $display("FAIL good_round_status got=%b exp=111110",
        {link_up, an_complete, speed_100, full_duplex, status_valid, timeout_err});
    end
    checks++;
    if (lc_cnt != 1) begin failures++; $display("FAIL good_round_link_change got=%0d exp=1", lc_cnt); end
    e = (log_q.size() >= 5) ? {log_q[2][22:16], log_q[3][22:16], log_q[4][22:16], 7'h0} : 28'hxxxxxxx;
    checks++;
    if (e !== {5'h01, 2'b10, 5'h04, 2'b10, 5'h05, 2'b10, 7'h0}) begin
      failures++; $display("FAIL good_round_read_order got=%h exp=%h", e, {5'h01, 2'b10, 5'h04, 2'b10, 5'h05, 2'b10, 7'h0});
    end
  endtask

  task automatic test_10fd();
    bit ok;
    anlpar_val = 16'h0061;
    lc_cnt = 0;
    wait_round(ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL res10fd_round got=no_round exp=round"); end
    checks++;
    if ({link_up, speed_100, full_duplex} !== 3'b101) begin
      failures++; $display("FAIL res10fd_speed_duplex got=%b exp=101", {link_up, speed_100, full_duplex});
    end
    checks++;
    if (lc_cnt != 0) begin failures++; $display("FAIL res10fd_no_link_change got=%0d exp=0", lc_cnt); end
  endtask

  task automatic test_timeout();
    int k = 0;
    int dt;
    bit ok;
    withhold_anar = 1;
    lc_cnt = 0;
    while (timeout_err !== 1'b1 && k < 800) begin step(); k++; end
    dt = cyc - anar_acc_cyc;
    checks++;
    if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_err_set got=%b exp=1", timeout_err); end
    checks++;
    if (dt != 53) begin failures++; $display("FAIL timeout_latency got=%0d exp=53", dt); end
    step();
    checks++;
    if ({link_up, status_valid, speed_100, full_duplex} !== 4'b0101) begin
      failures++; $display("FAIL timeout_outputs got=%b exp=0101", {link_up, status_valid, speed_100, full_duplex});
    end
    checks++;
    if (lc_cnt != 1) begin failures++; $display("FAIL timeout_link_change got=%0d exp=1", lc_cnt); end
    withhold_anar = 0;
    wait_round(ok);
    checks++;
    if ({ok, timeout_err, link_up} !== 3'b101) begin
      failures++; $display("FAIL timeout_recover got=%b exp=101", {ok, timeout_err, link_up});
    end
    checks++;
    if (lc_cnt != 2) begin failures++; $display("FAIL timeout_recover_link_change got=%0d exp=2", lc_cnt); end
  endtask

  task automatic test_restart();
    int k = 0;
    int lq;
    bit stable = 1;
    logic [27:0] snap, e;
    stall_req = 1;
    while (!stalled && k < 800) begin step(); k++; end
    step();
    snap = {cmd_phy_addr, cmd_reg_addr, cmd_opcode, cmd_data};
    checks++;
    if ({stalled, cmd_valid, snap} !== {2'b11, 5'h00, 5'h01, 2'b10, 16'h0000}) begin
      failures++; $display("FAIL restart_stalled_cmd got=%b_%h exp=11_%h", {stalled, cmd_valid}, snap, {5'h00, 5'h01, 2'b10, 16'h0000});
    end
    restart = 1'b1;
    repeat (6) begin
      step();
      if (cmd_valid !== 1'b1 || {cmd_phy_addr, cmd_reg_addr, cmd_opcode, cmd_data} !== snap) stable = 0;
    end
    checks++;
    if ({stable, init_done} !== 2'b11) begin failures++; $display("FAIL restart_cmd_held got=%b exp=11", {stable, init_done}); end
    lq = log_q.size();
    stall_req = 0;
    k = 0;
    while (init_done !== 1'b0 && k < 20) begin step(); k++; end
    checks++;
    if ({init_done, status_valid, link_up, full_duplex} !== 4'b0011) begin
      failures++; $display("FAIL restart_abort got=%b exp=0011", {init_done, status_valid, link_up, full_duplex});
    end
    k = 0;
    while (init_done !== 1'b1 && k < 300) begin step(); k++; end
    checks++;
    if (log_q.size() != lq + 3) begin failures++; $display("FAIL restart_cmd_count got=%0d exp=%0d", log_q.size(), lq + 3); end
    e = (log_q.size() > lq + 1) ? log_q[lq+1] : 28'hxxxxxxx;
    checks++;
    if (e !== {5'h00, 5'h09, 2'b01, 16'h0000}) begin failures++; $display("FAIL restart_gb_reissue got=%h exp=%h", e, {5'h00, 5'h09, 2'b01, 16'h0000}); end
    e = (log_q.size() > lq + 2) ? log_q[lq+2] : 28'hxxxxxxx;
    checks++;
    if (e !== {5'h00, 5'h00, 2'b01, 16'h1340}) begin failures++; $display("FAIL restart_bmcr_reissue got=%h exp=%h", e, {5'h00, 5'h00, 2'b01, 16'h1340}); end
    restart = 1'b0;
  endtask

  task automatic test_reset_mid_poll();
    int k = 0;
    bit ok;
    wait_round(ok);
    while (cmd_valid !== 1'b1 && k < 400) begin step(); k++; end
    checks++;
    if ({ok, status_valid, link_up, cmd_valid} !== 4'b1111) begin
      failures++; $display("FAIL midpoll_precondition got=%b exp=1111", {ok, status_valid, link_up, cmd_valid});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({link_up, an_complete, speed_100, full_duplex, status_valid, link_change, timeout_err, init_done, cmd_valid, cmd_opcode} !== 11'b00000000001) begin
      failures++; $display("FAIL midpoll_async_reset got=%b exp=00000000001",
        {link_up, an_complete, speed_100, full_duplex, status_valid, link_change, timeout_err, init_done, cmd_valid, cmd_opcode});
    end
  endtask

  task automatic test_no_gb();
    int k = 0;
    logic [27:0] e;
    step();
    log0_q.delete();
    rst = 1'b0;
    while (init_done_b !== 1'b1 && k < 100) begin step(); k++; end
    checks++;
    if ({init_done_b, log0_q.size() == 1} !== 2'b11) begin
      failures++; $display("FAIL nogb_cmd_count got=%b_%0d exp=1_1", init_done_b, log0_q.size());
    end
    e = (log0_q.size() > 0) ? log0_q[0] : 28'hxxxxxxx;
    checks++;
    if (e !== {5'h07, 5'h00, 2'b01, 16'h1340}) begin failures++; $display("FAIL nogb_bmcr_only got=%h exp=%h", e, {5'h07, 5'h00, 2'b01, 16'h1340}); end
  endtask

  initial begin
    rst = 1'b1;
    restart = 1'b0;
    cmd_ready = 1'b1;
    data_out = 16'h0000;
    data_out_valid = 1'b0;
    bmsr_val = 16'h782D;
    anar_val = 16'h01E1;
    anlpar_val = 16'h45E1;
    repeat (3) step();
    test_reset();
    test_bringup();
    test_good_round();
    test_10fd();
    test_timeout();
    test_restart();
    test_reset_mid_poll();
    test_no_gb();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
